// File: rtl/parking_pkg.sv
// Shared constants for the parking lot allocator: lot geometry, FSM encodings
// and the arbitration history values.
package parking_pkg;

  localparam int NUM_SPOTS = 8;
  localparam int IDX_W     = 3;

  localparam logic [2:0] ST_IDLE           = 3'd0;
  localparam logic [2:0] ST_SERVE_ENTRY    = 3'd1;
  localparam logic [2:0] ST_SERVE_EXIT     = 3'd2;
  localparam logic [2:0] ST_WAIT_ENTRY_LOW = 3'd3;
  localparam logic [2:0] ST_WAIT_EXIT_LOW  = 3'd4;

  localparam logic LAST_ENTRY = 1'b0;
  localparam logic LAST_EXIT  = 1'b1;

endpackage

// File: rtl/exit_parking_lot.sv
// Release decode: turns the park number of a departing car into a one-hot
// mask over the lot.
module exit_parking_lot #(
  parameter int NUM_SPOTS = parking_pkg::NUM_SPOTS,
  parameter int IDX_W     = parking_pkg::IDX_W
) (
  input  logic [IDX_W-1:0]     park_number,
  output logic [NUM_SPOTS-1:0] lot
);

  always_comb begin
    lot = '0;
    lot[park_number] = 1'b1;
  end

endmodule

// File: rtl/parking_lot_controller.sv
// Eight-space lot allocator: arbitrates entry/exit gate handshakes, assigns
// the lowest free space on entry and releases the named space on exit.
//
//   state             | meaning
//   ST_IDLE           | waiting for a request, tie goes opposite last_served
//   ST_SERVE_ENTRY    | allocate lowest free space, or reject when full
//   ST_SERVE_EXIT     | release the named space, or flag it as already free
//   ST_WAIT_ENTRY_LOW | entry grant given, waiting for entry_req to drop
//   ST_WAIT_EXIT_LOW  | exit grant given, waiting for exit_req to drop
module parking_lot_controller #(
  parameter int NUM_SPOTS = parking_pkg::NUM_SPOTS,
  parameter int IDX_W     = parking_pkg::IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entry_req,
  output logic                 entry_ack,
  output logic [IDX_W-1:0]     entry_park_number,
  output logic                 entry_reject,
  input  logic                 exit_req,
  input  logic [IDX_W-1:0]     exit_park_number,
  output logic                 exit_ack,
  output logic                 exit_error,
  output logic [NUM_SPOTS-1:0] occupancy,
  output logic [3:0]           free_count,
  output logic                 full,
  output logic                 empty
);

  import parking_pkg::*;

  logic [2:0]           state;
  logic                 last_served;
  logic [NUM_SPOTS-1:0] exit_mask;
  logic [IDX_W-1:0]     free_idx;
  logic                 exit_hit;

  function automatic logic [IDX_W-1:0] lowest_free(input logic [NUM_SPOTS-1:0] occ);
    lowest_free = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occ[i]) lowest_free = IDX_W'(i);
    end
  endfunction

  exit_parking_lot #(
    .NUM_SPOTS (NUM_SPOTS),
    .IDX_W     (IDX_W)
  ) u_exit_decode (
    .park_number (exit_park_number),
    .lot         (exit_mask)
  );

  assign free_idx = lowest_free(occupancy);
  assign exit_hit = |(occupancy & exit_mask);
  assign full     = (free_count == 4'd0);
  assign empty    = (free_count == 4'(NUM_SPOTS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      last_served       <= LAST_EXIT;
      occupancy         <= '0;
      free_count        <= 4'(NUM_SPOTS);
      entry_park_number <= '0;
      entry_ack         <= 1'b0;
      entry_reject      <= 1'b0;
      exit_ack          <= 1'b0;
      exit_error        <= 1'b0;
    end else begin
      entry_ack    <= 1'b0;
      entry_reject <= 1'b0;
      exit_ack     <= 1'b0;
      exit_error   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // last_served only records tie winners, so alternation is between contending gates
          if (entry_req && exit_req) begin
            if (last_served == LAST_EXIT) begin
              state       <= ST_SERVE_ENTRY;
              last_served <= LAST_ENTRY;
            end else begin
              state       <= ST_SERVE_EXIT;
              last_served <= LAST_EXIT;
            end
          end else if (entry_req) begin
            state <= ST_SERVE_ENTRY;
          end else if (exit_req) begin
            state <= ST_SERVE_EXIT;
          end
        end
        ST_SERVE_ENTRY: begin
          entry_ack <= 1'b1;
          if (full) begin
            entry_reject <= 1'b1;
          end else begin
            occupancy[free_idx] <= 1'b1;
            entry_park_number   <= free_idx;
            free_count          <= free_count - 4'd1;
          end
          state <= ST_WAIT_ENTRY_LOW;
        end
        ST_SERVE_EXIT: begin
          exit_ack <= 1'b1;
          if (exit_hit) begin
            occupancy  <= occupancy & ~exit_mask;
            free_count <= free_count + 4'd1;
          end else begin
            exit_error <= 1'b1;
          end
          state <= ST_WAIT_EXIT_LOW;
        end
        ST_WAIT_ENTRY_LOW: begin
          if (!entry_req) state <= ST_IDLE;
        end
        ST_WAIT_EXIT_LOW: begin
          if (!exit_req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_lot_controller.sv
// Directed bench for parking_lot_controller: a vector table of single
// transactions plus hand-written tie, empty-exit and mid-grant reset sequences.
module tb_parking_lot_controller;

  logic       clk;
  logic       rst_n;
  logic       entry_req;
  logic       entry_ack;
  logic [2:0] entry_park_number;
  logic       entry_reject;
  logic       exit_req;
  logic [2:0] exit_park_number;
  logic       exit_ack;
  logic       exit_error;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic       full;
  logic       empty;

  int n_pass;
  int n_total;

  typedef struct {
    logic       is_exit;
    logic [2:0] num;
    logic       flag;
    logic [2:0] park;
    logic [7:0] occ;
    logic [3:0] free;
  } vec_t;

  vec_t vecs[15];

  parking_lot_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .entry_req         (entry_req),
    .entry_ack         (entry_ack),
    .entry_park_number (entry_park_number),
    .entry_reject      (entry_reject),
    .exit_req          (exit_req),
    .exit_park_number  (exit_park_number),
    .exit_ack          (exit_ack),
    .exit_error        (exit_error),
    .occupancy         (occupancy),
    .free_count        (free_count),
    .full              (full),
    .empty             (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_status(input string tag, input logic [7:0] occ, input logic [3:0] free);
    check({tag, " occupancy"}, 32'(occupancy), 32'(occ));
    check({tag, " free_count"}, 32'(free_count), 32'(free));
    check({tag, " full"}, 32'(full), 32'(free == 4'd0));
    check({tag, " empty"}, 32'(empty), 32'(free == 4'd8));
  endtask

  task automatic check_reset_values(input string tag);
    check_status(tag, 8'h00, 4'd8);
    check({tag, " entry_ack"}, 32'(entry_ack), 32'd0);
    check({tag, " exit_ack"}, 32'(exit_ack), 32'd0);
    check({tag, " entry_reject"}, 32'(entry_reject), 32'd0);
    check({tag, " exit_error"}, 32'(exit_error), 32'd0);
    check({tag, " park_number"}, 32'(entry_park_number), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    entry_req = 1'b0;
    exit_req = 1'b0;
    exit_park_number = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single transaction: request seen at edge k, grant visible after edge k+1.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    if (v.is_exit) begin
      exit_park_number = v.num;
      exit_req = 1'b1;
    end else begin
      entry_req = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, " entry_ack"}, 32'(entry_ack), 32'(!v.is_exit));
    check({tag, " exit_ack"}, 32'(exit_ack), 32'(v.is_exit));
    check({tag, " entry_reject"}, 32'(entry_reject), 32'(!v.is_exit && v.flag));
    check({tag, " exit_error"}, 32'(exit_error), 32'(v.is_exit && v.flag));
    check({tag, " park_number"}, 32'(entry_park_number), 32'(v.park));
    check_status(tag, v.occ, v.free);
    @(negedge clk);
    entry_req = 1'b0;
    exit_req = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ack pulse end"}, 32'(entry_ack | exit_ack), 32'd0);
  endtask

  task automatic wait_ack(input logic want_exit, input string tag);
    int cyc;
    cyc = 0;
    while (cyc < 10 && !(want_exit ? exit_ack : entry_ack)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " ack seen"}, 32'(want_exit ? exit_ack : entry_ack), 32'd1);
  endtask

  initial begin
    logic [7:0] occ;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    exit_park_number = 3'd0;

    occ = 8'h00;
    for (int i = 0; i < 8; i++) begin
      occ[i] = 1'b1;
      vecs[i] = '{1'b0, 3'd0, 1'b0, 3'(i), occ, 4'(7 - i)};
    end
    vecs[8]  = '{1'b0, 3'd0, 1'b1, 3'd7, 8'hFF, 4'd0};
    vecs[9]  = '{1'b1, 3'd3, 1'b0, 3'd7, 8'hF7, 4'd1};
    vecs[10] = '{1'b0, 3'd0, 1'b0, 3'd3, 8'hFF, 4'd0};
    vecs[11] = '{1'b1, 3'd7, 1'b0, 3'd3, 8'h7F, 4'd1};
    vecs[12] = '{1'b1, 3'd7, 1'b1, 3'd3, 8'h7F, 4'd1};
    vecs[13] = '{1'b0, 3'd0, 1'b0, 3'd7, 8'hFF, 4'd0};
    vecs[14] = '{1'b1, 3'd0, 1'b0, 3'd7, 8'hFE, 4'd1};

    do_reset();
    #1;
    check_reset_values("reset");

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Exit of a space in an empty lot
    do_reset();
    run_vec('{1'b1, 3'd5, 1'b1, 3'd0, 8'h00, 4'd8}, 100);

    // Simultaneous requests: first tie goes to entry, the next one to exit
    run_vec('{1'b0, 3'd0, 1'b0, 3'd0, 8'h01, 4'd7}, 101);
    @(negedge clk);
    exit_park_number = 3'd0;
    entry_req = 1'b1;
    exit_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("tie1 entry_ack", 32'(entry_ack), 32'd1);
    check("tie1 exit_ack", 32'(exit_ack), 32'd0);
    check("tie1 park_number", 32'(entry_park_number), 32'd1);
    check("tie1 occupancy", 32'(occupancy), 32'h03);
    @(posedge clk);
    #1;
    check("tie1 exit held", 32'(exit_ack), 32'd0);
    @(negedge clk);
    entry_req = 1'b0;
    wait_ack(1'b1, "tie1 exit");
    check("tie1 exit occupancy", 32'(occupancy), 32'h02);
    check("tie1 exit_error", 32'(exit_error), 32'd0);
    @(negedge clk);
    exit_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exit_park_number = 3'd1;
    entry_req = 1'b1;
    exit_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("tie2 exit_ack", 32'(exit_ack), 32'd1);
    check("tie2 entry_ack", 32'(entry_ack), 32'd0);
    check_status("tie2", 8'h00, 4'd8);
    @(negedge clk);
    exit_req = 1'b0;
    wait_ack(1'b0, "tie2 entry");
    check("tie2 park_number", 32'(entry_park_number), 32'd0);
    check_status("tie2 entry", 8'h01, 4'd7);
    @(negedge clk);
    entry_req = 1'b0;
    @(posedge clk);

    // Reset asserted while SERVE_ENTRY is in flight
    @(negedge clk);
    entry_req = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    @(posedge clk);
    #1;
    check("reset hold entry_ack", 32'(entry_ack), 32'd0);
    @(negedge clk);
    entry_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post reset no ack", 32'(entry_ack), 32'd0);
    end
    check_status("post reset", 8'h00, 4'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/parking_lot_controller.md
# parking_lot_controller

Sequential allocator for the 8-space lot. It accepts car-entry and car-exit requests from the two gate interfaces and arbitrates between them with fair alternation. On entry it assigns the lowest-numbered free space; on exit it releases a space using the 3-bit to one-hot decode of `exit_parking_lot`. It holds the lot's occupancy state and the free/full status that the display and gate logic consume.

## Interface
- `NUM_SPOTS`, default 8: number of spaces. Only 8 is supported, matching the 3-bit park number and 8-bit location.
- `IDX_W`, default 3: park-number width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `entry_req` in 1: entry gate requests a space; level signal, 4-phase handshake.
- `entry_ack` out 1: one-cycle pulse, entry request served.
- `entry_park_number` out 3: assigned space; valid while `entry_ack`=1, held until the next entry service.
- `entry_reject` out 1: with `entry_ack`, lot full, no space assigned.
- `exit_req` in 1: exit gate requests release; level signal, 4-phase handshake.
- `exit_park_number` in 3: space being vacated; stable while `exit_req`=1.
- `exit_ack` out 1: one-cycle pulse, exit request served.
- `exit_error` out 1: with `exit_ack`, named space was already free; occupancy unchanged.
- `occupancy` out 8: bit i=1 means space i taken.
- `free_count` out 4: 0..8 free spaces.
- `full` out 1: `free_count`==0.
- `empty` out 1: `free_count`==8.

## Operation
- FSM states:
  - `IDLE`
  - `SERVE_ENTRY`
  - `SERVE_EXIT`
  - `WAIT_ENTRY_LOW`
  - `WAIT_EXIT_LOW`
- Transitions out of `IDLE`:
  - Only `entry_req`: go to `SERVE_ENTRY`.
  - Only `exit_req`: go to `SERVE_EXIT`.
  - Both: the side opposite `last_served` wins, and the loser stays pending. The 1-bit `last_served` resets to EXIT, so entry wins the first tie.
- `SERVE_ENTRY` to `WAIT_ENTRY_LOW`:
  - If not `full`: set the lowest clear `occupancy` bit, drive its index on `entry_park_number`, decrement `free_count`.
  - If `full`: assert `entry_reject` and leave state unchanged.
  - Assert `entry_ack` in both cases.
- `SERVE_EXIT` to `WAIT_EXIT_LOW`:
  - Decode `exit_park_number` to one-hot via the `exit_parking_lot` instance.
  - If that bit is set: clear it and increment `free_count`.
  - If that bit is clear: assert `exit_error` and leave state unchanged.
  - Assert `exit_ack` in both cases.
- `WAIT_x_LOW` to `IDLE`: once the corresponding req is 0. The other req is ignored until `IDLE`.
- `free_count` is updated in the same edge as `occupancy` and never wraps. Both full and empty boundaries are guarded by the reject/error paths.
- An X or Z on `exit_park_number` in `SERVE_EXIT` is a protocol violation. The bench flags it; the RTL is not required to handle it.

## Timing
- Reset values:
  - state `IDLE`
  - `occupancy`=8'h00
  - `free_count`=8
  - `full`=0
  - `empty`=1
  - `entry_ack`, `exit_ack`, `entry_reject`, `exit_error` = 0
  - `entry_park_number`=0
  - `last_served`=EXIT
- Req first seen high at edge k: state=SERVE at k.
- At edge k+1: ack/reject/error, `occupancy`, `free_count` and `entry_park_number` all update together.
- Ack and flags are high for exactly the cycle between edges k+1 and k+2. Request-to-ack latency is 2 edges.
- Minimum transaction is 3 edges, including one cycle with req low.
- `full` and `empty` are combinational from the registered `free_count`.
- `rst_n` low at any point, including mid-`SERVE` or `WAIT`: immediate return to reset values; any in-flight grant is discarded.

## Structure
- Shared package/header `parking_pkg`:
  - `NUM_SPOTS`, `IDX_W`
  - FSM state encodings
  - `LAST_ENTRY`/`LAST_EXIT` constants
- One sub-module: the existing `exit_parking_lot`, instantiated once for the release decode.
- The lowest-free-space priority encoder is a local function in `parking_lot_controller`, not a separate module.

## Test plan
- Reset then 8 sequential entries:
  - `entry_park_number` = 0,1,…,7.
  - `occupancy` = 8'hFF.
  - `full`=1 and `free_count`=0 after the 8th ack.
- Ninth entry while full: `entry_ack`=1, `entry_reject`=1, `occupancy` stays 8'hFF.
- From 8'hFF, exit space 3 then a new entry:
  - After the exit, `occupancy`=8'hF7 and `free_count`=1.
  - The entry is assigned space 3.
- Exit space 5 from empty lot: `exit_ack`=1, `exit_error`=1, `occupancy`=8'h00, `empty` stays 1.
- `entry_req` and `exit_req` raised on the same edge with space 0 occupied:
  - Entry is served first, getting space 1.
  - Exit of space 0 is acked only after `entry_req` drops.
  - A second simultaneous pair is won by exit.
- `rst_n` pulsed low during `SERVE_ENTRY`: no ack is produced, and all outputs return to reset values asynchronously.
